// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and WIDTH bounds.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  function automatic bit width_is_legal(input int w);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/bit_adder_cell.sv
// Combinational one-bit full-adder slice reused every cycle by serial_adder.
module bit_adder_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder slice plus carry flop, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
//
// state   | meaning
// IDLE    | waiting for an operand bundle, in_ready high
// RUN     | one sum bit per clock through the slice
// DONE    | result presented, waiting for out_ready
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  if (!width_is_legal(WIDTH)) begin : g_bad_width
    $error("serial_adder: WIDTH out of range 2..32");
  end

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic [CNT_W-1:0] r_cnt;

  logic w_s;
  logic w_co;
  logic w_accept;
  logic w_run;
  logic w_last;

  bit_adder_cell u_cell (
    .x  (r_a_sh[0]),
    .y  (r_b_sh[0]),
    .ci (r_carry),
    .s  (w_s),
    .co (w_co)
  );

  assign w_accept = in_valid && (r_state == ST_IDLE);
  assign w_run    = (r_state == ST_RUN);
  assign w_last   = w_run && (r_cnt == CNT_LAST);

  // Handshake outputs decode the registered state only.
  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state != ST_IDLE);
  assign sum       = r_sum;
  assign cout      = r_cout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (in_valid)  w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last)    w_state_nxt = ST_DONE;
      ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
      default:                w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_a_sh  <= a;
      r_b_sh  <= b;
      r_carry <= cin;
      r_cnt   <= '0;
      r_sum   <= '0;
    end else if (w_run) begin
      r_sum   <= {w_s, r_sum[WIDTH-1:1]};
      r_carry <= w_co;
      r_a_sh  <= {1'b0, r_a_sh[WIDTH-1:1]};
      r_b_sh  <= {1'b0, r_b_sh[WIDTH-1:1]};
      r_cnt   <= r_cnt + CNT_ONE;
      if (w_last) begin
        r_cout <= w_co;
      end
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic r_ovf;

  // On the last bit r_carry is the carry into the MSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_last) begin
      r_ovf <= r_carry ^ w_co;
    end
  end

  assign ovf = r_ovf;
`endif

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder built around a single one-bit full-adder slice plus a carry flip-flop.
- Accepts two WIDTH-bit operands and a carry-in through a valid/ready handshake.
- Feeds the slice LSB-first, one bit per clock, and collects the sum bits in a shift register.
- Presents the WIDTH-bit sum and carry-out through a second valid/ready handshake. Trades area for latency.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand bundle valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry into bit 0
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  a + b + cin, low WIDTH bits
- cout  output  1  carry out of bit WIDTH-1
- busy  output  1  high in RUN or DONE

Behaviour:
- Clocking and reset: one clock, clk; reset is asynchronous and active-high, rst.
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0.
  - Internal a_sh, b_sh, carry and bit counter all 0.
- States: IDLE, RUN, DONE. Fully registered FSM, one-hot or binary at implementer's choice.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at a rising edge: a_sh<=a, b_sh<=b, carry<=cin, cnt<=0, sum<=0, go RUN.
- RUN:
  - in_ready=0, busy=1.
  - Each edge, the slice inputs are a_sh[0], b_sh[0], carry.
  - Slice sum bit shifts into sum MSB (sum<={s,sum[WIDTH-1:1]}).
  - carry<=slice carry; a_sh and b_sh shift right by 1; cnt<=cnt+1.
  - When cnt==WIDTH-1 on that edge: cout<=slice carry, go DONE.
- DONE:
  - out_valid=1, busy=1; sum and cout held stable.
  - On out_ready at an edge: go IDLE, out_valid drops.
  - sum and cout keep their last value until the next accept.
- Latency: out_valid rises exactly WIDTH cycles after the accepting edge. Throughput: one result per WIDTH+2 cycles minimum.
- Handshake rules:
  - in_ready is a function of state only, with no combinational path from in_valid or out_ready.
  - in_valid while busy is ignored, and the operands are not captured.
  - out_ready low in DONE holds the result indefinitely (backpressure).
  - out_ready high outside DONE has no effect.
  - Operands a, b and cin only need to be stable on the accept edge.
- Counter: $clog2(WIDTH) bits, no wrap-around reached in legal operation.
- Reset mid-RUN or mid-DONE: immediate return to reset values; the partial result is discarded and no out_valid pulse is produced.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- When defined:
  - Adds output port ovf, 1 bit, with reset value 0.
  - ovf is the two's-complement signed overflow: the carry into bit WIDTH-1 XOR cout.
  - It is captured on the same edge as cout, and is valid and held under the same rules as sum.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package serial_adder_pkg: state enum constants (ST_IDLE, ST_RUN, ST_DONE) and the WIDTH legality bounds.
- Natural sub-module: bit_adder_cell, a combinational one-bit full-adder slice.
  - Inputs x, y, ci; outputs s, co.
  - s = x^y^ci; co = majority(x,y,ci).
  - Instantiated once; all sequential logic stays in serial_adder.

Test Plan:
1. WIDTH=8, a=8'h0F, b=8'h01, cin=0 -> out_valid exactly 8 cycles after accept; sum=8'h10, cout=0.
2. a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. With SERIAL_ADDER_OVF_EN: a=8'h7F, b=8'h01 -> sum=8'h80, ovf=1, cout=0; the FF+01 case gives ovf=0.
3. a=8'hAA, b=8'h55, cin=1 -> sum=8'h00, cout=1. Hold out_ready=0 for 5 cycles -> out_valid, sum and cout stable; in_ready=0 throughout.
4. Assert in_valid with a=8'h33 during RUN -> ignored; the result still matches the first operands. Back-to-back accepts: in_ready returns to 1 the cycle after the out handshake.
5. Assert rst asynchronously mid-RUN, at bit 4 -> all outputs return to reset values without waiting for a clock edge. The next transaction 8'h01+8'h02 yields 8'h03.
6. Randomised sweep of 1000 operand/cin sets at WIDTH=8 and WIDTH=16 -> {cout,sum} == a+b+cin for every case.
